// File: rtl/snd_mmc5_core.sv
// -----------------------------------------------------------------------------
// snd_mmc5_core
//
// MMC5 expansion audio: two square channels and an 8-bit PCM channel. CPU
// register accesses at $5000-$5015 are decoded here. The output is the
// unsigned mixed sample `vol`, which the mapper's delta-sigma DAC consumes.
//
// Build option:
//   SND_MMC5_PCM_EN - when defined, the PCM channel is built. This includes
//                     the $5010/$5011 decode, the $5010 read-back and irq_pcm.
//                     When undefined, pcm is 0, $5010/$5011 writes are
//                     ignored, $5010 is not claimed, and irq_pcm is 0.
//
// Parameters:
//   QF_PERIOD  cpu_ticks per quarter-frame tick (7457 gives 240 Hz)
//   VOL_W      width of the mixed output sample
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   map_rst   synchronous active-high reset
//   cpu_tick  one-clk pulse per CPU cycle
//   wr_stb    one-clk pulse, CPU write cycle complete
//   rd_stb    one-clk pulse, CPU read cycle complete
//   cpu_addr  CPU address
//   cpu_dat   CPU data (write data, or PRG data seen during reads)
//   map_dout  read data for $5010/$5015
//   map_oe    map_dout valid (combinational on address and read strobe)
//   irq_pcm   PCM IRQ request, level
//   vol       mixed sample, registered
// -----------------------------------------------------------------------------
module snd_mmc5_core #(
   parameter int QF_PERIOD = 7457,
   parameter int VOL_W     = 10
) (
   input  logic             clk,
   input  logic             map_rst,
   input  logic             cpu_tick,
   input  logic             wr_stb,
   input  logic             rd_stb,
   input  logic [15:0]      cpu_addr,
   input  logic [7:0]       cpu_dat,
   output logic [7:0]       map_dout,
   output logic             map_oe,
   output logic             irq_pcm,
   output logic [VOL_W-1:0] vol
);

   localparam logic [12:0] QF_LAST = 13'(QF_PERIOD - 1);

   // 2A03 length-counter lookup.
   function automatic logic [7:0] len_table(input logic [4:0] idx);
      logic [7:0] v;
      case (idx)
         5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
         5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
         5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
         5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
         5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
         5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
         5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
         5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
      endcase
      return v;
   endfunction

   // The MSB of each pattern is step 0.
   function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
      logic [7:0] pat;
      case (duty)
         2'd0:    pat = 8'b0100_0000;
         2'd1:    pat = 8'b0110_0000;
         2'd2:    pat = 8'b0111_1000;
         default: pat = 8'b1001_1111;
      endcase
      return pat[3'd7 - step];
   endfunction

   // ---------------------------------------------------------------- timing
   logic        apu_phase_reg;   // APU half-rate toggle
   logic [12:0] qf_cnt_reg;
   logic        hf_phase_reg;
   logic        half_tick;
   logic        qf;
   logic        hf;

   assign half_tick = cpu_tick & apu_phase_reg;
   assign qf        = cpu_tick & (qf_cnt_reg == QF_LAST);
   assign hf        = qf & hf_phase_reg;

   always_ff @(posedge clk) begin
      if (map_rst) begin
         apu_phase_reg <= 1'b0;
         qf_cnt_reg    <= 13'd0;
         hf_phase_reg  <= 1'b0;
      end else if (cpu_tick) begin
         apu_phase_reg <= ~apu_phase_reg;
         if (qf_cnt_reg == QF_LAST) begin
            qf_cnt_reg   <= 13'd0;
            hf_phase_reg <= ~hf_phase_reg;
         end else begin
            qf_cnt_reg <= qf_cnt_reg + 13'd1;
         end
      end
   end

   // ---------------------------------------------------------------- decode
   logic wr_sq;
   logic wr_5015;
   logic rd_5015;

   assign wr_sq   = wr_stb & (cpu_addr[15:3] == 13'h0A00);   // $5000-$5007
   assign wr_5015 = wr_stb & (cpu_addr == 16'h5015);
   assign rd_5015 = rd_stb & (cpu_addr == 16'h5015);

   logic [1:0] en_reg;

   always_ff @(posedge clk) begin
      if (map_rst)
         en_reg <= 2'b00;
      else if (wr_5015)
         en_reg <= cpu_dat[1:0];
   end

   // ------------------------------------------------------- square channels
   logic [3:0] sq_out [2];
   logic [1:0] len_nz;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sq
         localparam logic CH_SEL = (gi == 1);

         logic [1:0]  duty_reg;
         logic        halt_reg;
         logic        const_reg;
         logic [3:0]  vol_reg;
         logic [10:0] period_reg;
         logic [10:0] timer_reg;
         logic [2:0]  step_reg;
         logic [7:0]  len_reg;
         logic        start_reg;
         logic [3:0]  decay_reg;
         logic [3:0]  div_reg;
         logic        ch_wr;

         assign ch_wr = wr_sq & (cpu_addr[2] == CH_SEL);

         // Tick-driven updates come first. A coincident register write is
         // applied last so that it overrides them. For example, a reg3 start
         // flag lands after the qf envelope step, and a $5015 disable beats
         // a length load or decrement.
         always_ff @(posedge clk) begin
            if (map_rst) begin
               duty_reg   <= 2'd0;
               halt_reg   <= 1'b0;
               const_reg  <= 1'b0;
               vol_reg    <= 4'd0;
               period_reg <= 11'd0;
               timer_reg  <= 11'd0;
               step_reg   <= 3'd0;
               len_reg    <= 8'd0;
               start_reg  <= 1'b0;
               decay_reg  <= 4'd0;
               div_reg    <= 4'd0;
            end else begin
               if (half_tick) begin
                  if (timer_reg == 11'd0) begin
                     timer_reg <= period_reg;
                     step_reg  <= step_reg + 3'd1;
                  end else begin
                     timer_reg <= timer_reg - 11'd1;
                  end
               end

               if (qf) begin
                  if (start_reg) begin
                     start_reg <= 1'b0;
                     decay_reg <= 4'd15;
                     div_reg   <= vol_reg;
                  end else if (div_reg == 4'd0) begin
                     div_reg <= vol_reg;
                     if (decay_reg != 4'd0)
                        decay_reg <= decay_reg - 4'd1;
                     else if (halt_reg)
                        decay_reg <= 4'd15;
                  end else begin
                     div_reg <= div_reg - 4'd1;
                  end
               end

               if (hf && (len_reg != 8'd0) && !halt_reg)
                  len_reg <= len_reg - 8'd1;

               if (ch_wr) begin
                  case (cpu_addr[1:0])
                     2'd0: begin
                        duty_reg  <= cpu_dat[7:6];
                        halt_reg  <= cpu_dat[5];
                        const_reg <= cpu_dat[4];
                        vol_reg   <= cpu_dat[3:0];
                     end
                     2'd2: period_reg[7:0] <= cpu_dat;
                     2'd3: begin
                        period_reg[10:8] <= cpu_dat[2:0];
                        step_reg         <= 3'd0;
                        start_reg        <= 1'b1;
                        if (en_reg[gi])
                           len_reg <= len_table(cpu_dat[7:3]);
                     end
                     default: ;
                  endcase
               end

               if (wr_5015 && !cpu_dat[gi])
                  len_reg <= 8'd0;
            end
         end

         assign len_nz[gi] = (len_reg != 8'd0);
         assign sq_out[gi] = (len_nz[gi] && duty_bit(duty_reg, step_reg)) ?
                             (const_reg ? vol_reg : decay_reg) : 4'd0;
      end
   endgenerate

   // ----------------------------------------------------------- PCM channel
   logic [7:0] pcm_value;

`ifdef SND_MMC5_PCM_EN
   logic       mode_reg;        // 0 = write mode, 1 = read mode
   logic       irq_en_reg;
   logic       irq_flag_reg;
   logic [7:0] pcm_reg;
   logic       wr_5010;
   logic       wr_5011;
   logic       rd_5010;
   logic       rd_prg;

   assign wr_5010 = wr_stb & (cpu_addr == 16'h5010);
   assign wr_5011 = wr_stb & (cpu_addr == 16'h5011);
   assign rd_5010 = rd_stb & (cpu_addr == 16'h5010);
   assign rd_prg  = rd_stb & (cpu_addr[15:14] == 2'b10);    // $8000-$BFFF

   always_ff @(posedge clk) begin
      if (map_rst) begin
         mode_reg     <= 1'b0;
         irq_en_reg   <= 1'b0;
         irq_flag_reg <= 1'b0;
         pcm_reg      <= 8'd0;
      end else begin
         if (wr_5010) begin
            mode_reg   <= cpu_dat[0];
            irq_en_reg <= cpu_dat[7];
         end
         if (wr_5011 && !mode_reg && (cpu_dat != 8'd0))
            pcm_reg <= cpu_dat;
         // The clear is placed before the set, so a coincident set wins.
         if (rd_5010)
            irq_flag_reg <= 1'b0;
         if (rd_prg && mode_reg) begin
            if (cpu_dat == 8'd0)
               irq_flag_reg <= 1'b1;
            else
               pcm_reg <= cpu_dat;
         end
      end
   end

   assign pcm_value = pcm_reg;
   assign irq_pcm   = irq_flag_reg & irq_en_reg;
`else
   assign pcm_value = 8'd0;
   assign irq_pcm   = 1'b0;
`endif

   // ------------------------------------------------------------- read mux
   always_comb begin
      map_oe   = 1'b0;
      map_dout = 8'd0;
      if (rd_5015) begin
         map_oe   = 1'b1;
         map_dout = {6'd0, len_nz};
      end
`ifdef SND_MMC5_PCM_EN
      else if (rd_5010) begin
         map_oe   = 1'b1;
         map_dout = {irq_flag_reg, 7'd0};
      end
`endif
   end

   // ------------------------------------------------------------------ mix
   // The maximum value is 30*16 + 255 = 735, so the sum fits in 10 bits.
   logic [4:0]       sq_sum;
   logic [9:0]       mix_sum;
   logic [VOL_W-1:0] vol_reg;

   assign sq_sum  = {1'b0, sq_out[0]} + {1'b0, sq_out[1]};
   assign mix_sum = {1'b0, sq_sum, 4'd0} + {2'd0, pcm_value};

   always_ff @(posedge clk) begin
      if (map_rst)
         vol_reg <= '0;
      else
         vol_reg <= VOL_W'(mix_sum);
   end

   assign vol = vol_reg;

endmodule

// File: tb/tb_snd_mmc5_core.sv
module tb_snd_mmc5_core;

   localparam int QF = 37;   // short quarter frame keeps the run small

`ifdef SND_MMC5_PCM_EN
   localparam bit PCM = 1'b1;
`else
   localparam bit PCM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        map_rst;
   logic        cpu_tick;
   logic        wr_stb;
   logic        rd_stb;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dat;
   logic [7:0]  map_dout;
   logic        map_oe;
   logic        irq_pcm;
   logic [9:0]  vol;

   always #5 clk = ~clk;

   snd_mmc5_core #(.QF_PERIOD(QF), .VOL_W(10)) dut (
      .clk      (clk),
      .map_rst  (map_rst),
      .cpu_tick (cpu_tick),
      .wr_stb   (wr_stb),
      .rd_stb   (rd_stb),
      .cpu_addr (cpu_addr),
      .cpu_dat  (cpu_dat),
      .map_dout (map_dout),
      .map_oe   (map_oe),
      .irq_pcm  (irq_pcm),
      .vol      (vol)
   );

   int checks   = 0;
   int failures = 0;

   // ------------------------------------------------ behavioural reference
   int len_tab [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                        12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

   int m_tick, m_qf;
   int m_duty [2], m_halt [2], m_const [2], m_v [2], m_period [2], m_timer [2];
   int m_step [2], m_len [2], m_start [2], m_decay [2], m_div [2], m_en [2];
   int m_mode, m_irq_en, m_pcm, m_irq_flag, m_vol;

   function automatic bit duty_on(int d, int s);
      string p;
      case (d)
         0:       p = "01000000";
         1:       p = "01100000";
         2:       p = "01111000";
         default: p = "10011111";
      endcase
      return p.substr(s, s) == "1";
   endfunction

   function automatic int m_sq(int c);
      if (m_len[c] == 0 || !duty_on(m_duty[c], m_step[c])) return 0;
      return (m_const[c] != 0) ? m_v[c] : m_decay[c];
   endfunction

   function automatic bit exp_oe();
      return rd_stb && (cpu_addr == 16'h5015 || (PCM && cpu_addr == 16'h5010));
   endfunction

   function automatic int exp_dout();
      if (rd_stb && cpu_addr == 16'h5015)
         return ((m_len[1] != 0) ? 2 : 0) + ((m_len[0] != 0) ? 1 : 0);
      if (PCM && rd_stb && cpu_addr == 16'h5010)
         return m_irq_flag * 128;
      return 0;
   endfunction

   function automatic bit exp_irq();
      return (m_irq_flag != 0) && (m_irq_en != 0);
   endfunction

   task automatic model_reset();
      m_tick = 0; m_qf = 0;
      for (int c = 0; c < 2; c++) begin
         m_duty[c] = 0; m_halt[c] = 0; m_const[c] = 0; m_v[c] = 0; m_period[c] = 0;
         m_timer[c] = 0; m_step[c] = 0; m_len[c] = 0; m_start[c] = 0;
         m_decay[c] = 0; m_div[c] = 0; m_en[c] = 0;
      end
      m_mode = 0; m_irq_en = 0; m_pcm = 0; m_irq_flag = 0; m_vol = 0;
   endtask

   // Applies one clk worth of the inputs currently on the bus.
   task automatic model_clock();
      int nv, a, d, c;
      bit half, qf, hf;
      nv = (m_sq(0) + m_sq(1)) * 16 + m_pcm;
      if (map_rst) begin
         model_reset();
      end else begin
         if (cpu_tick) begin
            m_tick++;
            half = (m_tick % 2 == 0);
            qf   = (m_tick % QF == 0);
            hf   = 1'b0;
            if (qf) begin
               m_qf++;
               hf = (m_qf % 2 == 0);
            end
            for (int k = 0; k < 2; k++) begin
               if (half) begin
                  if (m_timer[k] == 0) begin
                     m_timer[k] = m_period[k];
                     m_step[k]  = (m_step[k] + 1) % 8;
                  end else m_timer[k]--;
               end
               if (qf) begin
                  if (m_start[k] != 0) begin
                     m_start[k] = 0; m_decay[k] = 15; m_div[k] = m_v[k];
                  end else if (m_div[k] == 0) begin
                     m_div[k] = m_v[k];
                     if (m_decay[k] > 0) m_decay[k]--;
                     else if (m_halt[k] != 0) m_decay[k] = 15;
                  end else m_div[k]--;
               end
               if (hf && m_len[k] > 0 && m_halt[k] == 0) m_len[k]--;
            end
         end
         a = int'(cpu_addr);
         d = int'(cpu_dat);
         if (wr_stb) begin
            if (a >= 'h5000 && a <= 'h5007) begin
               c = (a - 'h5000) / 4;
               case (a % 4)
                  0: begin
                     m_duty[c] = d / 64; m_halt[c] = (d / 32) % 2;
                     m_const[c] = (d / 16) % 2; m_v[c] = d % 16;
                  end
                  2: m_period[c] = (m_period[c] / 256) * 256 + d;
                  3: begin
                     m_period[c] = (d % 8) * 256 + m_period[c] % 256;
                     m_step[c] = 0; m_start[c] = 1;
                     if (m_en[c] != 0) m_len[c] = len_tab[d / 8];
                  end
                  default: ;
               endcase
            end else if (a == 'h5015) begin
               for (int k = 0; k < 2; k++) begin
                  m_en[k] = (d >> k) % 2;
                  if (m_en[k] == 0) m_len[k] = 0;
               end
            end else if (PCM && a == 'h5010) begin
               m_mode = d % 2; m_irq_en = d / 128;
            end else if (PCM && a == 'h5011) begin
               if (m_mode == 0 && d != 0) m_pcm = d;
            end
         end
         if (rd_stb && PCM) begin
            if (a == 'h5010) m_irq_flag = 0;
            if (a >= 'h8000 && a <= 'hBFFF && m_mode == 1) begin
               if (d == 0) m_irq_flag = 1;
               else m_pcm = d;
            end
         end
      end
      m_vol = nv;
   endtask

   // ------------------------------------------------------------ bus tasks
   task automatic drive(input bit t, input bit w, input bit r,
                        input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      cpu_tick = t; wr_stb = w; rd_stb = r; cpu_addr = a; cpu_dat = d;
      #1;
   endtask

   task automatic advance();
      model_clock();
      @(posedge clk);
      #1;
      wr_stb = 1'b0; rd_stb = 1'b0; cpu_tick = 1'b0;
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
      drive(1'b1, 1'b1, 1'b0, a, d);
      $display("WR  %h <= %h", a, d);
      advance();
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      map_rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 1'b0, 16'h5000 + 16'(i), 8'hFF);
         advance();
      end
      map_rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      checks++; if (vol !== 10'd0) begin failures++; $display("FAIL reset_vol got=%0d exp=0", vol); end
      checks++; if (irq_pcm !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq_pcm); end
      checks++; if (map_dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", map_dout); end
      checks++; if (map_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", map_oe); end
      advance();
      drive(1'b1, 1'b0, 1'b1, 16'h5015, 8'h00);
      checks++; if (map_dout !== 8'h00 || map_oe !== 1'b1) begin
         failures++; $display("FAIL reset_5015 got=%h/%b exp=00/1", map_dout, map_oe);
      end
      $display("RD  5015 -> %h", map_dout);
      advance();
   endtask

   task automatic test_square();
      int n240;
      n240 = 0;
      bus_wr(16'h5015, 8'h01);
      bus_wr(16'h5000, 8'hBF);
      bus_wr(16'h5002, 8'hFF);
      bus_wr(16'h5003, 8'h08);
      for (int i = 0; i < 4200; i++) begin
         drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
         advance();
         checks++; if (vol !== 10'(m_vol)) begin
            failures++; $display("FAIL square_vol cyc=%0d got=%0d exp=%0d", i, vol, m_vol);
         end
         if (vol == 10'd240) n240++;
      end
      // 512 ticks per step and 4 high steps in 8; about half of the run is high.
      checks++; if (n240 < 1800 || n240 > 2400) begin
         failures++; $display("FAIL square_high_count got=%0d exp=1800..2400", n240);
      end
   endtask

   task automatic test_envelope();
      bus_wr(16'h5000, 8'h0F);
      bus_wr(16'h5002, 8'h00);
      bus_wr(16'h5003, 8'h08);
      for (int i = 0; i < 20 * QF; i++) begin
         drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
         advance();
         checks++; if (vol !== 10'(m_vol)) begin
            failures++; $display("FAIL env_vol cyc=%0d got=%0d exp=%0d", i, vol, m_vol);
         end
      end
      bus_wr(16'h5000, 8'h21);   // loop on, V=1: decay 15..0 then reload
      bus_wr(16'h5003, 8'h08);
      for (int i = 0; i < 40 * QF; i++) begin
         drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
         advance();
         checks++; if (vol !== 10'(m_vol)) begin
            failures++; $display("FAIL env_loop_vol cyc=%0d got=%0d exp=%0d", i, vol, m_vol);
         end
      end
   endtask

   task automatic test_length();
      bus_wr(16'h5000, 8'h1F);
      bus_wr(16'h5003, 8'h18);   // index 3 -> length 2
      for (int i = 0; i < 6 * QF; i++) begin
         drive(1'b1, 1'b0, 1'b1, 16'h5015, 8'h00);
         checks++; if (map_dout !== 8'(exp_dout()) || map_oe !== 1'b1) begin
            failures++; $display("FAIL len_read cyc=%0d got=%h/%b exp=%h/1", i, map_dout, map_oe, exp_dout());
         end
         advance();
         checks++; if (vol !== 10'(m_vol)) begin
            failures++; $display("FAIL len_vol cyc=%0d got=%0d exp=%0d", i, vol, m_vol);
         end
      end
      drive(1'b1, 1'b0, 1'b1, 16'h5015, 8'h00);
      checks++; if (map_dout !== 8'h00) begin failures++; $display("FAIL len_expired got=%h exp=00", map_dout); end
      $display("RD  5015 -> %h", map_dout);
      advance();
   endtask

   task automatic test_disable();
      bus_wr(16'h5015, 8'h03);
      bus_wr(16'h5000, 8'hFF);
      bus_wr(16'h5004, 8'hFF);
      bus_wr(16'h5002, 8'h00);
      bus_wr(16'h5006, 8'h00);
      bus_wr(16'h5003, 8'hF8);
      bus_wr(16'h5007, 8'hF8);
      for (int i = 0; i < 20; i++) begin drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0); advance(); end
      drive(1'b1, 1'b0, 1'b1, 16'h5015, 8'h00);
      checks++; if (map_dout !== 8'h03) begin failures++; $display("FAIL dis_before got=%h exp=03", map_dout); end
      advance();
      bus_wr(16'h5015, 8'h00);
      drive(1'b1, 1'b0, 1'b1, 16'h5015, 8'h00);
      checks++; if (map_dout !== 8'h00) begin failures++; $display("FAIL dis_read got=%h exp=00", map_dout); end
      $display("RD  5015 -> %h", map_dout);
      advance();
      checks++; if (vol !== 10'd0 || vol !== 10'(m_vol)) begin
         failures++; $display("FAIL dis_vol got=%0d exp=0", vol);
      end
   endtask

   task automatic test_back_to_back();
      bit found;
      found = 1'b0;
      bus_wr(16'h5015, 8'h01);
      bus_wr(16'h5000, 8'h03);
      bus_wr(16'h5002, 8'h00);
      bus_wr(16'h5003, 8'h08);
      for (int i = 0; i < 2 * QF && !found; i++) begin
         if ((m_tick + 1) % QF == 0) found = 1'b1;
         else begin drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0); advance(); end
      end
      checks++; if (!found) begin failures++; $display("FAIL b2b_align got=0 exp=1"); end
      bus_wr(16'h5003, 8'h08);    // reg3 write on the qf clk
      bus_wr(16'h5000, 8'h02);    // back-to-back writes
      bus_wr(16'h5003, 8'h0F);
      for (int i = 0; i < 4 * QF; i++) begin
         drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
         advance();
         checks++; if (vol !== 10'(m_vol)) begin
            failures++; $display("FAIL b2b_vol cyc=%0d got=%0d exp=%0d", i, vol, m_vol);
         end
      end
   endtask

   task automatic test_pcm();
      bus_wr(16'h5015, 8'h00);
      bus_wr(16'h5010, 8'h00);
      bus_wr(16'h5011, 8'h80);
      drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0); advance();
      checks++; if (vol !== 10'(PCM ? 128 : 0)) begin
         failures++; $display("FAIL pcm_write got=%0d exp=%0d", vol, PCM ? 128 : 0);
      end
      bus_wr(16'h5011, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0); advance();
      checks++; if (vol !== 10'(PCM ? 128 : 0)) begin
         failures++; $display("FAIL pcm_zero_ignored got=%0d exp=%0d", vol, PCM ? 128 : 0);
      end
      bus_wr(16'h5010, 8'h81);
      drive(1'b1, 1'b0, 1'b1, 16'h8000, 8'h00);
      $display("RD  8000 <- 00");
      advance();
      checks++; if (irq_pcm !== PCM) begin failures++; $display("FAIL pcm_irq_set got=%b exp=%b", irq_pcm, PCM); end
      drive(1'b1, 1'b0, 1'b1, 16'h5010, 8'h00);
      checks++; if (map_oe !== PCM || map_dout !== (PCM ? 8'h80 : 8'h00)) begin
         failures++; $display("FAIL pcm_5010_read got=%h/%b exp=%h/%b", map_dout, map_oe, PCM ? 8'h80 : 8'h00, PCM);
      end
      $display("RD  5010 -> %h", map_dout);
      advance();
      checks++; if (irq_pcm !== 1'b0) begin failures++; $display("FAIL pcm_irq_clear got=%b exp=0", irq_pcm); end
      drive(1'b1, 1'b0, 1'b1, 16'h9ABC, 8'h55);
      advance();
      drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0); advance();
      checks++; if (vol !== 10'(PCM ? 85 : 0)) begin
         failures++; $display("FAIL pcm_read_capture got=%0d exp=%0d", vol, PCM ? 85 : 0);
      end
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [7:0]  d;
      int k;
      bit t, w, r;
      for (int i = 0; i < 3000; i++) begin
         t = ($urandom_range(0, 9) < 8);
         w = 1'b0; r = 1'b0; a = 16'h0000; d = 8'($urandom);
         if (t && $urandom_range(0, 3) == 0) begin
            k = $urandom_range(0, 11);
            if (k < 8) begin
               w = 1'b1; a = 16'h5000 + 16'(k);
               if (k % 4 == 3) d = {5'($urandom_range(0, 31)), 3'($urandom_range(0, 1))};
               else if (k % 4 == 2) d = 8'($urandom_range(0, 15));
            end else if (k == 8) begin
               w = 1'b1; a = 16'h5015; d = ($urandom_range(0, 3) != 0) ? 8'h03 : 8'($urandom_range(0, 2));
            end else if (k == 9) begin
               w = 1'b1; a = 16'h5010; d = {1'($urandom), 6'd0, 1'($urandom)};
            end else if (k == 10) begin
               w = 1'b1; a = 16'h5011;
            end else begin
               r = 1'b1;
               case ($urandom_range(0, 3))
                  0:       a = 16'h5015;
                  1:       a = 16'h5010;
                  2:       begin a = 16'h8000 | 16'($urandom_range(0, 16'h3FFF)); if ($urandom_range(0, 2) == 0) d = 8'h00; end
                  default: a = 16'hC123;
               endcase
            end
            $display("TXN %s %h %h", w ? "WR" : "RD", a, d);
         end
         drive(t, w, r, a, d);
         checks++; if (map_oe !== exp_oe() || map_dout !== 8'(exp_dout())) begin
            failures++; $display("FAIL rnd_read cyc=%0d got=%h/%b exp=%h/%b", i, map_dout, map_oe, exp_dout(), exp_oe());
         end
         advance();
         checks++; if (vol !== 10'(m_vol) || irq_pcm !== exp_irq()) begin
            failures++; $display("FAIL rnd_out cyc=%0d got=%0d/%b exp=%0d/%b", i, vol, irq_pcm, m_vol, exp_irq());
         end
      end
   endtask

   initial begin
      map_rst = 1'b1; cpu_tick = 1'b0; wr_stb = 1'b0; rd_stb = 1'b0;
      cpu_addr = 16'h0000; cpu_dat = 8'h00;
      model_reset();
      test_reset();
      test_square();
      test_envelope();
      test_length();
      test_disable();
      test_back_to_back();
      test_pcm();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
